divider: RTL and testbench
==========================

DIVIDER -- requirements
Module: divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand and result width; the block is verified only at 32.
REQ-002 Port clk, input, 1, rising-edge clock.
REQ-003 Port reset, input, 1, asynchronous, active-high reset.
REQ-004 Port div_on, input, 1, start request, sampled only in IDLE.
REQ-005 Port A, input, WIDTH, signed dividend, sampled in INIT.
REQ-006 Port B, input, WIDTH, signed divisor, sampled in INIT.
REQ-007 Port quo, output, WIDTH, signed quotient (LO).
REQ-008 Port rem, output, WIDTH, signed remainder (HI).
REQ-009 Port div_done, output, 1, high for exactly one cycle when the result is valid.
REQ-010 Port div_zero, output, 1, divide-by-zero flag.
REQ-011 Port busy, output, 1, high in every state except IDLE.

Function
REQ-012 The block SHALL implement states IDLE, INIT, LOOP, FIX and DONE, encoded in the shared package.
REQ-013 IDLE: on a clock edge with div_on=1, the next state SHALL be INIT, and div_zero SHALL be cleared; otherwise the block stays in IDLE.
REQ-014 INIT: the block SHALL register A and B, sign flags sA=A[MSB] and sQ=A[MSB]^B[MSB], and the magnitudes |A| and |B| (two's complement negate when negative), SHALL clear the partial remainder and the counter, and SHALL enter LOOP.
REQ-015 INIT with B==0: the next state SHALL be DONE, div_zero SHALL be set, and quo and rem SHALL keep their previous values.
REQ-016 LOOP: each cycle SHALL do one restoring step, in this order: shift {R,Q} left 1 with the next dividend MSB; if R>=|B|, subtract |B| and set Q[0]=1; increment the counter.
REQ-017 LOOP SHALL run exactly WIDTH cycles and then enter FIX.
REQ-018 FIX: quo SHALL be Q negated if sQ, else Q; rem SHALL be R negated if sA, else R; both outputs SHALL update on this edge; the next state SHALL be DONE.
REQ-019 The quotient SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend, so that A = quo*B + rem.
REQ-020 The case 0x80000000 / 0xFFFFFFFF SHALL give quo=0x80000000 and rem=0, with no flag; this is natural wrap.
REQ-021 DONE: div_done SHALL be 1, and the next state SHALL be IDLE.
REQ-022 Latency: with acceptance at edge N, div_done SHALL be high in the cycle after edge N+WIDTH+2, which is edge N+34 at width 32.
REQ-023 Latency with divide-by-zero: div_done SHALL be high in the cycle after edge N+1.
REQ-024 div_on outside IDLE SHALL be ignored, with no queuing.
REQ-025 A and B changes after INIT SHALL NOT affect the result in progress.
REQ-026 quo and rem SHALL hold their values from DONE until the next FIX or reset.
REQ-027 div_zero SHALL hold until the next accepted start or reset.

Reset
REQ-028 On reset=1, the state SHALL become IDLE immediately.
REQ-029 On reset=1, quo, rem, the internal registers and the counter SHALL become 0.
REQ-030 On reset=1, div_done, div_zero and busy SHALL become 0.
REQ-031 A reset during LOOP or FIX SHALL abort the operation, with no div_done pulse.

Structure
REQ-032 The state encoding typedef and the latency constant WIDTH+2 SHALL live in the shared processor package, next to the multiplier-related constants.
REQ-033 One combinational sub-module, div_step, SHALL perform one shift/compare/subtract iteration (inputs R, Q, |B|; outputs R', Q').
REQ-034 The FSM, counter and sign fix-up SHALL stay in divider.

Verification
REQ-035 Scenario: A=7, B=2 -> quo=3, rem=1, with div_done exactly 34 edges after acceptance.
REQ-036 Scenario: A=-7 (0xFFFFFFF9), B=2 -> quo=0xFFFFFFFD, rem=0xFFFFFFFF.
REQ-037 Scenario: A=7, B=-2 (0xFFFFFFFE) -> quo=0xFFFFFFFD, rem=1; and A=-7, B=-2 -> quo=3, rem=0xFFFFFFFF.
REQ-038 Scenario: A=5, B=0 -> div_zero=1, div_done one cycle after INIT, quo and rem unchanged from the previous result.
REQ-039 Scenario: A=0x80000000, B=0xFFFFFFFF -> quo=0x80000000, rem=0, div_zero=0.
REQ-040 Scenario: reset asserted at LOOP iteration 10, then div_on pulsed during busy of a new operation -> outputs 0 after reset, no div_done; the second div_on is ignored; a new 100/7 gives quo=14, rem=2.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared processor package: multiply/divide constants and the divider state encoding.
package divider_pkg;

    localparam int MUL_WIDTH   = 32;
    localparam int DIV_WIDTH   = 32;
    // Edges from start acceptance to the FIX edge: INIT, WIDTH loop steps, FIX.
    localparam int DIV_LATENCY = DIV_WIDTH + 2;

    typedef logic [2:0] divState_t;

    localparam divState_t IDLE = 3'd0;
    localparam divState_t INIT = 3'd1;
    localparam divState_t LOOP = 3'd2;
    localparam divState_t FIX  = 3'd3;
    localparam divState_t DONE = 3'd4;

endpackage

// File: rtl/divider_div_step.sv
// One restoring-division iteration: shift {R,Q} left, then conditionally subtract |B|.
module div_step
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] r_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // The shifted remainder can reach 2*|B|-1, so it needs one extra bit for the compare.
    always_comb begin
        shifted = {r_i, q_i[WIDTH-1]};
        diff    = shifted - {1'b0, b_i};
        r_o     = shifted[WIDTH-1:0];
        q_o     = {q_i[WIDTH-2:0], 1'b0};
        if (shifted >= {1'b0, b_i}) begin
            r_o    = diff[WIDTH-1:0];
            q_o[0] = 1'b1;
        end
    end

endmodule

// File: rtl/divider.sv
// Multi-cycle signed restoring divider: quotient truncates toward zero,
// remainder carries the dividend's sign.
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_on,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             div_done,
    output logic             div_zero,
    busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    divState_t        state_q,  state_d;
    logic [WIDTH-1:0] remAcc_q, remAcc_d;
    logic [WIDTH-1:0] quoAcc_q, quoAcc_d;
    logic [WIDTH-1:0] magB_q,   magB_d;
    logic             signA_q,  signA_d;
    logic             signQ_q,  signQ_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] quo_q,    quo_d;
    logic [WIDTH-1:0] rem_q,    rem_d;
    logic             zero_q,   zero_d;

    logic [WIDTH-1:0] stepRem;
    logic [WIDTH-1:0] stepQuo;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_i (remAcc_q),
        .q_i (quoAcc_q),
        .b_i (magB_q),
        .r_o (stepRem),
        .q_o (stepQuo)
    );

    // The quotient register starts as |A| and is consumed MSB-first while quotient bits fill in from the bottom.
    always_comb begin
        state_d  = state_q;
        remAcc_d = remAcc_q;
        quoAcc_d = quoAcc_q;
        magB_d   = magB_q;
        signA_d  = signA_q;
        signQ_d  = signQ_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (div_on) begin
                    state_d = INIT;
                    zero_d  = 1'b0;
                end
            end
            INIT: begin
                signA_d  = A[WIDTH-1];
                signQ_d  = A[WIDTH-1] ^ B[WIDTH-1];
                quoAcc_d = A[WIDTH-1] ? -A : A;
                magB_d   = B[WIDTH-1] ? -B : B;
                remAcc_d = '0;
                cnt_d    = '0;
                if (B == '0) begin
                    state_d = DONE;
                    zero_d  = 1'b1;
                end else begin
                    state_d = LOOP;
                end
            end
            LOOP: begin
                remAcc_d = stepRem;
                quoAcc_d = stepQuo;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quo_d   = signQ_q ? -quoAcc_q : quoAcc_q;
                rem_d   = signA_q ? -remAcc_q : remAcc_q;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            remAcc_q <= '0;
            quoAcc_q <= '0;
            magB_q   <= '0;
            signA_q  <= 1'b0;
            signQ_q  <= 1'b0;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            remAcc_q <= remAcc_d;
            quoAcc_q <= quoAcc_d;
            magB_q   <= magB_d;
            signA_q  <= signA_d;
            signQ_q  <= signQ_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            zero_q   <= zero_d;
        end
    end

    assign quo      = quo_q;
    assign rem      = rem_q;
    assign div_zero = zero_q;
    assign div_done = (state_q == DONE);
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_divider.sv
// Directed and random checks of the signed divider using an expected-result scoreboard.
module tb_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        div_on;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        div_done;
    logic        div_zero;
    logic        busy;

    typedef struct {
        string       tag;
        logic [31:0] quo;
        logic [31:0] rem;
        logic        zero;
        int          latency;
    } exp_t;

    exp_t        sb[$];
    int          checkCount = 0;
    int          passCount  = 0;
    int          failCount  = 0;
    int          lastLatency;
    logic [31:0] lastQuo = '0;
    logic [31:0] lastRem = '0;

    divider #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .div_on   (div_on),
        .A        (A),
        .B        (B),
        .quo      (quo),
        .rem      (rem),
        .div_done (div_done),
        .div_zero (div_zero),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checkCount++;
        assert (obs === expv) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference model: signed division truncating toward zero, with natural wrap on overflow.
    task automatic pushModel(input string tag, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   sa;
        int   sbv;
        sa  = int'(a);
        sbv = int'(b);
        e.tag = tag;
        if (b == 32'd0) begin
            e.quo = lastQuo;
            e.rem = lastRem;
            e.zero = 1'b1;
            e.latency = 1;
        end else begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.quo = 32'h8000_0000;
                e.rem = 32'd0;
            end else begin
                e.quo = 32'(sa / sbv);
                e.rem = 32'(sa % sbv);
            end
            e.zero = 1'b0;
            e.latency = 34;
            lastQuo = e.quo;
            lastRem = e.rem;
        end
        sb.push_back(e);
    endtask

    task automatic pushConst(input string tag, input logic [31:0] q, input logic [31:0] r,
                             input logic z, input int lat);
        exp_t e;
        e.tag = tag;
        e.quo = q;
        e.rem = r;
        e.zero = z;
        e.latency = lat;
        if (!z) begin
            lastQuo = q;
            lastRem = r;
        end
        sb.push_back(e);
    endtask

    // Starts one division, scrambles A/B after INIT, optionally pulses div_on mid-operation,
    // and counts edges from acceptance until div_done is seen.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit pulseBusy);
        int cycles;
        @(negedge clk);
        A = a;
        B = b;
        div_on = 1'b1;
        @(posedge clk);
        #1;
        div_on = 1'b0;
        cycles = 0;
        while (cycles < 200) begin
            @(posedge clk);
            cycles++;
            #1;
            if (div_done) break;
            if (cycles == 1) begin
                A = $urandom;
                B = $urandom;
            end
            if (pulseBusy && cycles == 5) begin
                div_on = 1'b1;
                A = 32'd1000;
                B = 32'd3;
            end
            if (pulseBusy && cycles == 6) div_on = 1'b0;
        end
        lastLatency = cycles;
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({e.tag, "_latency"}, 32'(lastLatency), 32'(e.latency));
        check({e.tag, "_quo"}, quo, e.quo);
        check({e.tag, "_rem"}, rem, e.rem);
        check({e.tag, "_zero"}, {31'd0, div_zero}, {31'd0, e.zero});
        @(posedge clk);
        #1;
        check({e.tag, "_done_one_cycle"}, {31'd0, div_done}, 32'd0);
        check({e.tag, "_idle_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int sawDone;
        logic [31:0] ra;
        logic [31:0] rb;

        reset  = 1'b1;
        div_on = 1'b0;
        A      = '0;
        B      = '0;
        #12;
        check("reset_quo", quo, 32'd0);
        check("reset_rem", rem, 32'd0);
        check("reset_done", {31'd0, div_done}, 32'd0);
        check("reset_zero", {31'd0, div_zero}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        pushConst("pos_pos", 32'd3, 32'd1, 1'b0, 34);
        applyStimulus(32'd7, 32'd2, 1'b0);
        checkOutput();

        pushConst("neg_pos", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34);
        applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b0);
        checkOutput();

        pushConst("pos_neg", 32'hFFFF_FFFD, 32'd1, 1'b0, 34);
        applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b0);
        checkOutput();

        pushConst("neg_neg", 32'd3, 32'hFFFF_FFFF, 1'b0, 34);
        applyStimulus(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0);
        checkOutput();

        pushConst("div_by_zero", 32'd3, 32'hFFFF_FFFF, 1'b1, 1);
        applyStimulus(32'd5, 32'd0, 1'b0);
        checkOutput();
        repeat (3) @(posedge clk);
        #1;
        check("zero_flag_holds", {31'd0, div_zero}, 32'd1);

        pushConst("min_by_neg1", 32'h8000_0000, 32'd0, 1'b0, 34);
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        checkOutput();

        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom_range(1, 50000);
            if (i == 1) rb = -rb;
            pushModel($sformatf("rand%0d", i), ra, rb);
            applyStimulus(ra, rb, 1'b0);
            checkOutput();
        end

        // Abort an operation after ten loop iterations.
        @(negedge clk);
        A = 32'd1000;
        B = 32'd3;
        div_on = 1'b1;
        @(posedge clk);
        #1;
        div_on = 1'b0;
        repeat (11) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_quo", quo, 32'd0);
        check("abort_rem", rem, 32'd0);
        check("abort_done", {31'd0, div_done}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_zero", {31'd0, div_zero}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        sawDone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (div_done) sawDone++;
        end
        check("abort_no_done", 32'(sawDone), 32'd0);

        pushConst("after_abort", 32'd14, 32'd2, 1'b0, 34);
        applyStimulus(32'd100, 32'd7, 1'b1);
        checkOutput();
        sawDone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (div_done || busy) sawDone++;
        end
        check("ignored_start_not_queued", 32'(sawDone), 32'd0);
        check("after_abort_hold_quo", quo, 32'd14);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
